// File: rtl/icache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// icache_refill_ctrl
//
// Miss-handling sequencer for the instruction fetch stage. When the current
// PC misses in the direct-mapped instruction cache, the PC is frozen. The
// 16-byte line (4 x 32-bit words) is read from instruction memory and
// written into the cache. The lookup is then replayed.
//
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   fetch_addr     current PC presented to the cache
//   fetch_valid    fetch_addr is a live lookup this cycle
//   cache_hit      same-cycle cache lookup result for fetch_addr
//   redirect       taken branch / PC source change this cycle
//   stall          hold PC register (combinational)
//   mem_req        line read request to instruction memory
//   mem_addr       line-aligned request address
//   mem_ready      memory accepts the request
//   mem_valid      mem_line valid, single-cycle pulse
//   mem_line       returned line, word 0 in bits [31:0]
//   fill_en        one-cycle cache write strobe
//   fill_index     cache line to write
//   fill_tag       tag to write (marks the line valid)
//   fill_data      registered line data
//   miss_count     saturating count of misses started
//   dbgState       current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 FILL, 4 REPLAY)
//
// Memory handshake: a request transfers on the rising edge where
// mem_req && mem_ready are both high. Once raised, mem_req and mem_addr stay
// stable until that transfer. The only exception is a redirect that arrives
// without mem_ready; it withdraws the request. Only one request is ever
// outstanding. The response side has no backpressure. mem_valid is a
// one-cycle pulse that is accepted only while waiting for the line.
// ---------------------------------------------------------------------------
module icache_refill_ctrl #(
  parameter int INDEX_BITS = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            fetch_addr,
  input  logic                   fetch_valid,
  input  logic                   cache_hit,
  input  logic                   redirect,
  output logic                   stall,
  output logic                   mem_req,
  output logic [31:0]            mem_addr,
  input  logic                   mem_ready,
  input  logic                   mem_valid,
  input  logic [127:0]           mem_line,
  output logic                   fill_en,
  output logic [INDEX_BITS-1:0]  fill_index,
  output logic [27-INDEX_BITS:0] fill_tag,
  output logic [127:0]           fill_data,
  output logic [CNT_WIDTH-1:0]   miss_count,
  output logic [2:0]             dbgState
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_FILL   = 3'd3,
    S_REPLAY = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                   stateQ, stateD;
  logic [31:0]              missAddr;
  logic [CNT_WIDTH-1:0]     missCount;
  logic [INDEX_BITS-1:0]    fillIndexQ;
  logic [27-INDEX_BITS:0]   fillTagQ;
  logic [127:0]             fillDataQ;

  logic missStart;
  logic lineReturn;

  // A miss that coincides with a redirect belongs to a squashed path and
  // is not chased.
  assign missStart  = (stateQ == S_IDLE) && fetch_valid && !cache_hit && !redirect;
  // Stale returns (for example after a reset that interrupted a transfer)
  // are ignored because mem_valid is accepted only in WAIT.
  assign lineReturn = (stateQ == S_WAIT) && mem_valid;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ <= S_IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      S_IDLE: begin
        if (missStart) stateD = S_REQ;
      end
      S_REQ: begin
        // An accepted transfer takes precedence over a simultaneous redirect.
        if (mem_ready)     stateD = S_WAIT;
        else if (redirect) stateD = S_IDLE;
      end
      S_WAIT: begin
        // redirect is ignored here; the returning line is still good data.
        if (mem_valid) stateD = S_FILL;
      end
      S_FILL:   stateD = S_REPLAY;
      // One extra stalled cycle lets the cache read see the written line.
      S_REPLAY: stateD = S_IDLE;
      default:  stateD = S_IDLE;
    endcase
  end

  // Miss address and saturating miss counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      missAddr  <= 32'h0;
      missCount <= '0;
    end else if (missStart) begin
      // Line alignment is done by masking the offset bits only.
      missAddr <= {fetch_addr[31:4], 4'h0};
      if (missCount != CNT_MAX) begin
        missCount <= missCount + CNT_ONE;
      end
    end
  end

  // Fill registers capture the returned line and hold it outside FILL.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fillIndexQ <= '0;
      fillTagQ   <= '0;
      fillDataQ  <= '0;
    end else if (lineReturn) begin
      fillIndexQ <= missAddr[4+INDEX_BITS-1:4];
      fillTagQ   <= missAddr[31:4+INDEX_BITS];
      fillDataQ  <= mem_line;
    end
  end

  // Outputs
  assign stall      = (stateQ != S_IDLE) || (fetch_valid && !cache_hit);
  assign mem_req    = (stateQ == S_REQ);
  assign mem_addr   = missAddr;
  assign fill_en    = (stateQ == S_FILL);
  assign fill_index = fillIndexQ;
  assign fill_tag   = fillTagQ;
  assign fill_data  = fillDataQ;
  assign miss_count = missCount;
  assign dbgState   = stateQ;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;

  // ---------------- clock / reset ----------------
  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  fetch_addr;
  logic         fetch_valid, cache_hit, redirect;
  logic         mem_ready, mem_valid;
  logic [127:0] mem_line;

  logic         stall, mem_req, fill_en;
  logic [31:0]  mem_addr;
  logic [3:0]   fill_index;
  logic [23:0]  fill_tag;
  logic [127:0] fill_data;
  logic [15:0]  miss_count;
  logic [2:0]   dbg_state;

  logic         stall2, mem_req2, fill_en2;
  logic [31:0]  mem_addr2;
  logic [3:0]   fill_index2;
  logic [23:0]  fill_tag2;
  logic [127:0] fill_data2;
  logic [1:0]   miss_count2;
  logic [2:0]   dbg_state2;

  always #5 clock = ~clock;

  icache_refill_ctrl #(.INDEX_BITS(4), .CNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .cache_hit(cache_hit), .redirect(redirect), .stall(stall), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_line(mem_line),
    .fill_en(fill_en), .fill_index(fill_index), .fill_tag(fill_tag), .fill_data(fill_data),
    .miss_count(miss_count), .dbgState(dbg_state)
  );

  icache_refill_ctrl #(.INDEX_BITS(4), .CNT_WIDTH(2)) dut_sat (
    .clock(clock), .reset(reset), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .cache_hit(cache_hit), .redirect(redirect), .stall(stall2), .mem_req(mem_req2),
    .mem_addr(mem_addr2), .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_line(mem_line),
    .fill_en(fill_en2), .fill_index(fill_index2), .fill_tag(fill_tag2), .fill_data(fill_data2),
    .miss_count(miss_count2), .dbgState(dbg_state2)
  );

  localparam logic [2:0] ST_IDLE = 3'd0, ST_REQ = 3'd1, ST_WAIT = 3'd2,
                         ST_FILL = 3'd3, ST_REPLAY = 3'd4;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  int exp_count = 0;
  logic [31:0]  exp_q[$];   // expected request addresses
  logic [155:0] fill_q[$];  // expected {index, tag, data}

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] sat_exp(input int n);
    return (n > 3) ? 2'd3 : 2'(n);
  endfunction

  // Monitor runs on the falling edge, away from input updates.
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_req && mem_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) check("unexpected_xfer", 1, 0);
        else check("sb_mem_addr", mem_addr, exp_q.pop_front());
      end
      if (fill_en) begin
        if (fill_q.size() == 0) check("unexpected_fill", 1, 0);
        else check("sb_fill", {fill_index, fill_tag, fill_data}, fill_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    fetch_valid = 1'b0; cache_hit = 1'b0; redirect = 1'b0;
    mem_ready = 1'b0; mem_valid = 1'b0;
  endtask

  // Full miss with acc cycles of backpressure and ret cycles of return wait.
  task automatic do_miss(input logic [31:0] addr, input logic [127:0] line,
                         input int acc, input int ret,
                         input logic redir_acc, input logic redir_wait);
    logic [31:0] aligned;
    aligned = {addr[31:4], 4'h0};
    fetch_addr = addr; fetch_valid = 1'b1; cache_hit = 1'b0; redirect = 1'b0;
    mem_ready = 1'b0; mem_valid = 1'b0;
    exp_q.push_back(aligned);
    fill_q.push_back({addr[7:4], addr[31:8], line});
    #1 check("miss_detect_stall", stall, 1);
    tick();
    exp_count++;
    check("req_state", dbg_state, ST_REQ);
    check("miss_count", miss_count, exp_count);
    check("miss_count_sat", miss_count2, sat_exp(exp_count));
    for (int i = 0; i < acc; i++) begin
      check("req_held", mem_req, 1);
      check("addr_held", mem_addr, aligned);
      tick();
    end
    mem_ready = 1'b1; redirect = redir_acc;
    check("req_at_accept", mem_req, 1);
    tick();
    mem_ready = 1'b0; redirect = redir_wait;
    check("req_dropped", mem_req, 0);
    check("wait_state", dbg_state, ST_WAIT);
    for (int i = 0; i < ret; i++) begin
      tick();
      check("wait_hold", dbg_state, ST_WAIT);
    end
    mem_valid = 1'b1; mem_line = line;
    tick();
    mem_valid = 1'b0; mem_line = {4{$urandom}}; redirect = 1'b0;
    check("fill_en", fill_en, 1);
    check("fill_index", fill_index, addr[7:4]);
    check("fill_tag", fill_tag, addr[31:8]);
    check("fill_data", fill_data, line);
    tick();
    check("replay_fill_off", fill_en, 0);
    check("replay_stall", stall, 1);
    check("fill_data_hold", fill_data, line);
    cache_hit = 1'b1;
    tick();
    check("release_stall", stall, 0);
    check("back_idle", dbg_state, ST_IDLE);
    fetch_valid = 1'b0; cache_hit = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct packed {
    logic fv;
    logic hit;
    logic redir;
    logic exp_stall;
  } idle_vec_t;

  idle_vec_t vecs[6];

  initial begin
    vecs[0] = '{fv: 1'b0, hit: 1'b0, redir: 1'b0, exp_stall: 1'b0};
    vecs[1] = '{fv: 1'b0, hit: 1'b1, redir: 1'b0, exp_stall: 1'b0};
    vecs[2] = '{fv: 1'b1, hit: 1'b1, redir: 1'b0, exp_stall: 1'b0};
    vecs[3] = '{fv: 1'b1, hit: 1'b0, redir: 1'b1, exp_stall: 1'b1};
    vecs[4] = '{fv: 1'b1, hit: 1'b1, redir: 1'b1, exp_stall: 1'b0};
    vecs[5] = '{fv: 1'b0, hit: 1'b0, redir: 1'b1, exp_stall: 1'b0};

    reset = 1'b1;
    fetch_addr = 32'h0; mem_line = '0;
    drive_idle();
    repeat (2) @(posedge clock);
    #1;
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_outputs", {stall, mem_req, mem_addr, fill_en, fill_index, fill_tag},
          {1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 24'h0});
    check("rst_fill_data", fill_data, 128'h0);
    check("rst_count", miss_count, 0);
    reset = 1'b0;
    tick();

    // Idle-state vectors, each held across one edge; none may start a miss.
    for (int i = 0; i < 6; i++) begin
      fetch_addr = $urandom;
      fetch_valid = vecs[i].fv; cache_hit = vecs[i].hit; redirect = vecs[i].redir;
      #1 check("vec_stall", stall, vecs[i].exp_stall);
      tick();
      check("vec_no_req", mem_req, 0);
      check("vec_idle", dbg_state, ST_IDLE);
    end
    drive_idle();
    check("vec_count", miss_count, 0);

    // Hit path.
    for (int i = 0; i < 10; i++) begin
      fetch_addr = $urandom; fetch_valid = 1'b1; cache_hit = 1'b1;
      #1 check("hit_stall", stall, 0);
      check("hit_no_req", mem_req, 0);
      tick();
    end
    drive_idle();
    check("hit_count", miss_count, 0);

    // Basic miss.
    do_miss(32'h0000_0048,
            {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA},
            0, 2, 1'b0, 1'b0);
    check("basic_xfers", n_xfer, 1);

    // Backpressure: five cycles without mem_ready.
    do_miss(32'hDEAD_BEE4, {4{$urandom}}, 5, 1, 1'b0, 1'b0);
    check("bp_xfers", n_xfer, 2);

    // Redirect during WAIT, and redirect coinciding with accept.
    do_miss(32'h1234_56F0, {4{$urandom}}, 0, 3, 1'b0, 1'b1);
    do_miss(32'h8000_0A1C, {4{$urandom}}, 2, 0, 1'b1, 1'b0);
    check("redir_xfers", n_xfer, 4);

    // Redirect in REQ without mem_ready withdraws the request.
    fetch_addr = 32'h0000_3330; fetch_valid = 1'b1; cache_hit = 1'b0;
    tick();
    exp_count++;
    check("wd_req", mem_req, 1);
    redirect = 1'b1; fetch_valid = 1'b0;
    tick();
    redirect = 1'b0;
    check("wd_idle", dbg_state, ST_IDLE);
    check("wd_req_off", mem_req, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wd_no_fill", fill_en, 0);
    end
    check("wd_count", miss_count, exp_count);

    // Reset during WAIT, then a stale return after release.
    fetch_addr = 32'h0000_7770; fetch_valid = 1'b1; cache_hit = 1'b0;
    exp_q.push_back(32'h0000_7770);
    tick();
    mem_ready = 1'b1; fetch_valid = 1'b0;
    tick();
    mem_ready = 1'b0;
    check("rw_wait", dbg_state, ST_WAIT);
    reset = 1'b1;
    #1;
    check("rw_async_state", dbg_state, ST_IDLE);
    check("rw_async_addr", mem_addr, 32'h0);
    check("rw_async_count", miss_count, 0);
    tick();
    reset = 1'b0;
    exp_count = 0;
    tick(); tick();
    mem_valid = 1'b1; mem_line = {4{$urandom}};
    tick();
    mem_valid = 1'b0;
    check("rw_no_fill", fill_en, 0);
    check("rw_state", dbg_state, ST_IDLE);
    check("rw_outs", {mem_req, mem_addr, fill_index, fill_tag}, 0);
    check("rw_fill_data", fill_data, 128'h0);
    fetch_valid = 1'b1; cache_hit = 1'b1;
    #1 check("rw_stall_hit", stall, 0);
    cache_hit = 1'b0; redirect = 1'b1;
    #1 check("rw_stall_miss", stall, 1);
    tick();
    drive_idle();
    check("rw_stay_idle", dbg_state, ST_IDLE);

    // Saturation: five misses on the 2-bit counter instance.
    for (int i = 0; i < 5; i++) begin
      do_miss({$urandom_range(0, 32'hFFFF), 16'h0} | 32'(i << 4), {4{$urandom}},
              $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 1'b0);
    end
    check("sat_count2", miss_count2, 2'd3);
    check("sat_count16", miss_count, 16'd5);

    tick();
    check("sb_addr_empty", exp_q.size(), 0);
    check("sb_fill_empty", fill_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
